fios_mm_seq: RTL
================

FIOS_MM_SEQ -- requirements
Module: fios_mm_seq

Interface
REQ-001 The block SHALL have parameter s, default 8: number of 17-bit operand words.
REQ-002 The block SHALL have parameter PE_NB, default 8: number of PEs controlled; legal range 1..s.
REQ-003 The block SHALL have parameter PE_DELAY, default 7: cycles between PE i and PE i+1 schedules.
REQ-004 The block SHALL have parameter LOOP_DELAY, default 0: extra cycles on the last-PE feedback path.
REQ-005 The block SHALL have parameter DSP_REG_LEVEL, default 2: DSP pipeline depth, 1..3.
REQ-006 The block SHALL have one clock; reset is synchronous and active-high: clock_i  in  1  rising-edge clock.
REQ-007 The block SHALL have port reset_i  in  1  synchronous active-high reset.
REQ-008 The block SHALL have port start_i  in  1  request one multiplication, sampled when ready_o=1.
REQ-009 The block SHALL have port ready_o  out  1  idle, start accepted this cycle.
REQ-010 The block SHALL have port word_valid_o  out  1  external b/p word word_idx_o is to be driven on b_i/p_i this cycle.
REQ-011 The block SHALL have port word_idx_o  out  $clog2(s+1)  operand word index.
REQ-012 The block SHALL have port res_valid_o  out  1  datapath RES_o holds result word res_idx_o.
REQ-013 The block SHALL have port res_idx_o  out  $clog2(s+1)  result word index.
REQ-014 The block SHALL have port done_o  out  1  one-cycle pulse, last result word captured.
REQ-015 The block SHALL have per-PE control outputs a_reg_en_o, m_reg_en_o, CREG_en_o, RES_delay_en_o, C_input_delay_en_o (PE_NB x1), mux_A_sel_o, mux_B_sel_o, mux_C_sel_o (PE_NB x2), and OPMODE_o (PE_NB x7).
REQ-016 The block SHALL have port FIOS_input_sel_o  out  1  select fed-back operands at PE 0, for PE_NB<s.

Function
REQ-017 The states SHALL be IDLE, FEED, RUN, DRAIN and DONE; IDLE->FEED on start_i; FEED->RUN after s+1 word cycles; RUN->DRAIN at cycle FIRST_RES; DRAIN->DONE after s+1 result cycles; DONE->IDLE after one cycle.
REQ-018 Cycle 0 SHALL be the cycle after start is accepted; word_valid_o SHALL be 1 on cycles 0..s with word_idx_o=cycle, where word s is the zero-extension word.
REQ-019 A free-running 16-bit cycle counter SHALL count from 0 at acceptance and SHALL be held at 0 in IDLE.
REQ-020 PE i iteration r SHALL start at T = (r*PE_NB+i)*PE_DELAY + r*(1+LOOP_DELAY); local step k = cycle-T, active for 0<=k<=s+1.
REQ-021 At step k=0 the PE SHALL assert a_reg_en, with mux_A_sel=0, mux_B_sel=0, OPMODE=0000101.
REQ-022 At step k=DSP_REG_LEVEL the PE SHALL assert m_reg_en, with mux_A_sel=1, mux_B_sel=1, OPMODE=0110101.
REQ-023 At other active steps the PE SHALL drive mux_A_sel=2, OPMODE=1010101 (PCIN>>17 + M), CREG_en=1, and RES_delay_en=1 when DSP_REG_LEVEL>=2.
REQ-024 For DSP_REG_LEVEL=3, mux_C_sel SHALL be 2 during active steps and 0 otherwise.
REQ-025 C_input_delay_en SHALL be asserted for PE i+1 whenever PE i is active.
REQ-026 When a PE is inactive, all its enables SHALL be 0 and its OPMODE SHALL be 0000000.
REQ-027 Iterations SHALL total s, and iteration index r SHALL wrap to PE 0 (FIOS_input_sel_o=1 for every r>=1).
REQ-028 FIRST_RES SHALL equal s*PE_DELAY + (ceil(s/PE_NB)-1)*(1+LOOP_DELAY) + DSP_REG_LEVEL + 2.
REQ-029 res_valid_o SHALL be 1 on cycles FIRST_RES..FIRST_RES+s, with res_idx_o=cycle-FIRST_RES.
REQ-030 done_o SHALL be 1 in the DONE state.
REQ-031 start_i SHALL be ignored outside IDLE.

Reset
REQ-032 When reset_i=1 at a clock edge, the state SHALL be IDLE and all counters SHALL be 0.
REQ-033 After reset, ready_o SHALL be 1 and every other output SHALL be 0.
REQ-034 A reset mid-operation SHALL abort the multiplication with no done_o pulse.

Configuration
REQ-035 With FIOS_SEQ_BUSY_ERR_EN defined, start_i outside IDLE SHALL set a sticky err_o output, cleared only by reset.
REQ-036 Without FIOS_SEQ_BUSY_ERR_EN, no err_o port SHALL exist and start_i outside IDLE SHALL be ignored silently.

Verification
REQ-037 With s=8, PE_NB=8, PE_DELAY=7, DSP_REG_LEVEL=2, a start pulse SHALL give word_valid_o on cycles 0..8, res_valid_o on cycles 60..68, and done_o on cycle 69.
REQ-038 In the same configuration, a_reg_en_o[3] SHALL be high only on cycle 21, and m_reg_en_o[3] only on cycle 23.
REQ-039 With PE_NB=3 (FOLD), FIOS_input_sel_o SHALL be 0 until the start of iteration 3 and 1 afterwards; the DSP result SHALL match a golden Montgomery model.
REQ-040 Asserting reset_i at cycle 30 SHALL return all outputs to reset values on cycle 31, with no done_o.
REQ-041 A start_i on cycle 10 while busy SHALL leave the timing unchanged, and err_o=1 only when the macro is defined.
REQ-042 A start_i in the cycle after done_o SHALL be accepted, and back-to-back multiplications SHALL produce identical timing.

Source files
------------

// File: rtl/fios_mm_seq.sv
// fios_mm_seq: schedule controller for a FIOS Montgomery multiplier PE chain.
// Define FIOS_SEQ_BUSY_ERR_EN to add a sticky err_o flag for starts requested while busy.
module fios_mm_seq #(
  parameter int s = 8,
  parameter int PE_NB = 8,
  parameter int PE_DELAY = 7,
  parameter int LOOP_DELAY = 0,
  parameter int DSP_REG_LEVEL = 2,
  localparam int IW = $clog2(s + 1)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic                  ready_o,
  output logic                  word_valid_o,
  output logic [IW-1:0]         word_idx_o,
  output logic                  res_valid_o,
  output logic [IW-1:0]         res_idx_o,
  output logic                  done_o,
  output logic [PE_NB-1:0]      a_reg_en_o,
  output logic [PE_NB-1:0]      m_reg_en_o,
  output logic [PE_NB-1:0]      CREG_en_o,
  output logic [PE_NB-1:0]      RES_delay_en_o,
  output logic [PE_NB-1:0]      C_input_delay_en_o,
  output logic [PE_NB-1:0][1:0] mux_A_sel_o,
  output logic [PE_NB-1:0][1:0] mux_B_sel_o,
  output logic [PE_NB-1:0][1:0] mux_C_sel_o,
  output logic [PE_NB-1:0][6:0] OPMODE_o,
  output logic                  FIOS_input_sel_o
`ifdef FIOS_SEQ_BUSY_ERR_EN
  ,
  output logic                  err_o
`endif
);
  localparam int ROUNDS = (s + PE_NB - 1) / PE_NB;
  localparam int FIRST_RES = s * PE_DELAY + (ROUNDS - 1) * (1 + LOOP_DELAY) + DSP_REG_LEVEL + 2;
  localparam logic [15:0] FEED_END = 16'(s);
  localparam logic [15:0] RES_START = 16'(FIRST_RES);
  localparam logic [15:0] RES_END = 16'(FIRST_RES + s);
  localparam logic [15:0] FOLD_START = 16'(PE_NB * PE_DELAY + 1 + LOOP_DELAY);
  typedef enum logic [2:0] {IDLE, FEED, RUN, DRAIN, DONE} state_t;
  state_t st, st_n;
  logic [15:0] cnt, cnt_n;
  logic busy;
  logic [PE_NB-1:0] act, a_en, m_en, mid;
  logic [15:0] stp [PE_NB];
  function automatic logic [15:0] t_of(input int r, input int i);
    return 16'((r * PE_NB + i) * PE_DELAY + r * (1 + LOOP_DELAY));
  endfunction
  always_comb begin
    st_n = st;
    cnt_n = cnt + 16'd1;
    case (st)
      IDLE: begin
        cnt_n = '0;
        st_n = start_i ? FEED : IDLE;
      end
      FEED: st_n = cnt == FEED_END ? RUN : FEED;
      RUN: st_n = cnt == RES_START - 16'd1 ? DRAIN : RUN;
      DRAIN: st_n = cnt == RES_END ? DONE : DRAIN;
      default: begin
        st_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end
  assign busy = st_n != IDLE;
  // outputs are decoded from the next state so they leave the register aligned with the cycle count
  always_comb begin
    act = '0;
    for (int i = 0; i < PE_NB; i++) begin
      stp[i] = '0;
      for (int r = 0; r < ROUNDS; r++)
        if (busy && r * PE_NB + i < s && cnt_n >= t_of(r, i) && cnt_n <= t_of(r, i) + 16'(s + 1)) begin
          act[i] = 1'b1;
          stp[i] = cnt_n - t_of(r, i);
        end
    end
  end
  always_comb
    for (int i = 0; i < PE_NB; i++) begin
      a_en[i] = act[i] && stp[i] == '0;
      m_en[i] = act[i] && stp[i] == 16'(DSP_REG_LEVEL);
    end
  assign mid = act & ~a_en & ~m_en;
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      st <= IDLE;
      cnt <= '0;
      ready_o <= 1'b1;
      word_valid_o <= 1'b0;
      word_idx_o <= '0;
      res_valid_o <= 1'b0;
      res_idx_o <= '0;
      done_o <= 1'b0;
      FIOS_input_sel_o <= 1'b0;
      a_reg_en_o <= '0;
      m_reg_en_o <= '0;
      CREG_en_o <= '0;
      RES_delay_en_o <= '0;
      C_input_delay_en_o <= '0;
      mux_A_sel_o <= '0;
      mux_B_sel_o <= '0;
      mux_C_sel_o <= '0;
      OPMODE_o <= '0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      ready_o <= !busy;
      word_valid_o <= st_n == FEED;
      word_idx_o <= st_n == FEED ? IW'(cnt_n) : '0;
      res_valid_o <= st_n == DRAIN;
      res_idx_o <= st_n == DRAIN ? IW'(cnt_n - RES_START) : '0;
      done_o <= st_n == DONE;
      FIOS_input_sel_o <= busy && PE_NB < s && cnt_n >= FOLD_START;
      a_reg_en_o <= a_en;
      m_reg_en_o <= m_en;
      CREG_en_o <= mid;
      RES_delay_en_o <= DSP_REG_LEVEL >= 2 ? mid : '0;
      C_input_delay_en_o <= act << 1;
      for (int i = 0; i < PE_NB; i++) begin
        mux_A_sel_o[i] <= m_en[i] ? 2'd1 : mid[i] ? 2'd2 : 2'd0;
        mux_B_sel_o[i] <= {1'b0, m_en[i]};
        mux_C_sel_o[i] <= DSP_REG_LEVEL == 3 && act[i] ? 2'd2 : 2'd0;
        OPMODE_o[i] <= a_en[i] ? 7'b0000101 : m_en[i] ? 7'b0110101 : mid[i] ? 7'b1010101 : 7'b0000000;
      end
    end
  end
`ifdef FIOS_SEQ_BUSY_ERR_EN
  always_ff @(posedge clock_i) err_o <= reset_i ? 1'b0 : err_o | (start_i && st != IDLE);
`endif
endmodule
